// File: rtl/program_loader.sv
// Program loader: receives a framed byte stream (A5, N, N data bytes[, checksum]) and writes it into program RAM.
// Latency: each accepted data byte is written one cycle after the transfer; the CPU restart pulse comes one cycle after the last byte.
// Backpressure: in_ready is low only during the single RELEASE cycle and while rst is high. Optional checksum byte: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 13500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_restart,
  output logic              load_done,
  output logic              load_error
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter and length need one extra bit so that N = 2**ADDR_W is representable.
  localparam int CW    = ADDR_W + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
`ifdef LOADER_CHECKSUM_EN
    CSUM,
`endif
    RELEASE
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, len;
  logic [7:0]      sum;
  logic [TW-1:0]   timer;

  logic xfer, timed, timeout_hit;
  logic start, take_len, wr, finish, err;

  assign in_ready    = !rst && (state != RELEASE);
  assign xfer        = in_valid && in_ready;
`ifdef LOADER_CHECKSUM_EN
  assign timed       = (state == LEN) || (state == DATA) || (state == CSUM);
`else
  assign timed       = (state == LEN) || (state == DATA);
`endif
  assign timeout_hit = timed && !xfer && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Next-state and per-cycle action decode.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    take_len   = 1'b0;
    wr         = 1'b0;
    finish     = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        // Anything other than the sync byte is silently dropped.
        if (xfer && in_data == 8'hA5) begin
          next_state = LEN;
          start      = 1'b1;
        end
      end
      LEN: begin
        if (xfer) begin
          if (in_data != 8'd0 && {24'd0, in_data} <= 32'(DEPTH)) begin
            next_state = DATA;
            take_len   = 1'b1;
          end else begin
            next_state = IDLE;
            err        = 1'b1;
          end
        end
      end
      DATA: begin
        // 0xA5 here is plain payload; there is no resync mid-frame.
        if (xfer) begin
          wr = 1'b1;
          if (cnt + CW'(1) == len) begin
`ifdef LOADER_CHECKSUM_EN
            next_state = CSUM;
`else
            next_state = RELEASE;
            finish     = 1'b1;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          if (in_data == sum) begin
            next_state = RELEASE;
            finish     = 1'b1;
          end else begin
            next_state = IDLE;
            err        = 1'b1;
          end
        end
      end
`endif
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (timeout_hit) begin
      next_state = IDLE;
      err        = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Datapath, RAM write port, CPU control and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 8'd0;
      cpu_halt    <= 1'b0;
      cpu_restart <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      cnt         <= '0;
      len         <= '0;
      sum         <= 8'd0;
      timer       <= '0;
    end else begin
      mem_we      <= wr;
      cpu_restart <= finish;
      if (take_len) begin
        len <= CW'(in_data);
        cnt <= '0;
        sum <= 8'd0;
      end
      if (wr) begin
        mem_addr  <= cnt[ADDR_W-1:0];
        mem_wdata <= in_data;
        cnt       <= cnt + CW'(1);
        sum       <= sum + in_data;
      end
      if (start) begin
        cpu_halt   <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
      end
      if (finish) begin
        cpu_halt  <= 1'b0;
        load_done <= 1'b1;
      end
      // On error the CPU stays halted: RAM may hold a partial image.
      if (err) load_error <= 1'b1;
      if (xfer || !timed) timer <= '0;
      else                timer <= timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames, error paths, timeout, max length and mid-frame reset.
// Writes and restart pulses are collected by a negedge monitor; all checks go through check().
// Expectations depending on the checksum byte follow LOADER_CHECKSUM_EN.
module tb_program_loader;

  localparam int AW = 4;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          cpu_halt;
  logic          cpu_restart;
  logic          load_done;
  logic          load_error;

  int n_checks = 0;
  int n_fail   = 0;
  int n_restart = 0;
  logic [15:0] wq[$];

  program_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_halt(cpu_halt),
    .cpu_restart(cpu_restart), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Record every RAM write and restart cycle mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (mem_we) wq.push_back({8'(mem_addr), mem_wdata});
    if (cpu_restart) n_restart++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] wq_at(input int i);
    if (i < wq.size()) return wq[i];
    return 16'hFFFF;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one byte and hold it until it is accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_for_byte", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    wq.delete();
    n_restart = 0;
  endtask

  initial begin
    logic [7:0] csum;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 8'hA5;
    idle(1);
    check("rst_in_ready",    in_ready,    1'b0);
    check("rst_mem_we",      mem_we,      1'b0);
    check("rst_mem_addr",    mem_addr,    4'd0);
    check("rst_mem_wdata",   mem_wdata,   8'd0);
    check("rst_cpu_halt",    cpu_halt,    1'b0);
    check("rst_cpu_restart", cpu_restart, 1'b0);
    check("rst_load_done",   load_done,   1'b0);
    check("rst_load_error",  load_error,  1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    idle(2);
    check("idle_in_ready", in_ready, 1'b1);

    // Basic 3-byte frame.
    clear_log();
    send_byte(8'hA5);
    check("f1_halt_after_sync", cpu_halt, 1'b1);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);
    idle(4);
    check("f1_nwrites", wq.size(), 3);
    check("f1_w0", wq_at(0), 16'h0011);
    check("f1_w1", wq_at(1), 16'h0122);
    check("f1_w2", wq_at(2), 16'h0233);
    check("f1_restarts", n_restart, 1);
    check("f1_done", load_done, 1'b1);
    check("f1_halt", cpu_halt, 1'b0);
    check("f1_err", load_error, 1'b0);

    // Leading garbage, single byte; write strobe one cycle after the transfer.
    clear_log();
    send_byte(8'h00); send_byte(8'hFF);
    check("f2_no_halt_on_garbage", cpu_halt, 1'b0);
    send_byte(8'hA5);
    check("f2_done_cleared", load_done, 1'b0);
    send_byte(8'h01); send_byte(8'h2F);
    check("f2_we_next_cycle", mem_we, 1'b1);
    check("f2_addr", mem_addr, 4'd0);
    check("f2_wdata", mem_wdata, 8'h2F);
    send_byte(8'h2F);
    idle(4);
    check("f2_nwrites", wq.size(), 1);
    check("f2_w0", wq_at(0), 16'h002F);
    check("f2_done", load_done, 1'b1);
    check("f2_restarts", n_restart, 1);

    // 0xA5 inside the payload is data.
    clear_log();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h07); send_byte(8'hAC);
    idle(4);
    check("f3_nwrites", wq.size(), 2);
    check("f3_w0", wq_at(0), 16'h00A5);
    check("f3_w1", wq_at(1), 16'h0107);
    check("f3_done", load_done, 1'b1);

    // Bad checksum (0x10+0x20 = 0x30, sent 0x31).
    clear_log();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    idle(4);
    check("f4_nwrites", wq.size(), 2);
`ifdef LOADER_CHECKSUM_EN
    check("f4_err", load_error, 1'b1);
    check("f4_halt", cpu_halt, 1'b1);
    check("f4_done", load_done, 1'b0);
    check("f4_restarts", n_restart, 0);
`else
    check("f4_err", load_error, 1'b0);
    check("f4_halt", cpu_halt, 1'b0);
    check("f4_done", load_done, 1'b1);
    check("f4_restarts", n_restart, 1);
`endif

    // Length out of range: 17 and 0.
    clear_log();
    send_byte(8'hA5);
    check("f5_err_cleared", load_error, 1'b0);
    send_byte(8'h11);
    idle(3);
    check("f5_len17_err", load_error, 1'b1);
    check("f5_len17_halt", cpu_halt, 1'b1);
    check("f5_len17_nwrites", wq.size(), 0);
    send_byte(8'hA5); send_byte(8'h00);
    idle(3);
    check("f5_len0_err", load_error, 1'b1);
    check("f5_len0_nwrites", wq.size(), 0);
    check("f5_restarts", n_restart, 0);

    // Inter-byte timeout: error exactly on the 50th idle cycle, then recovery.
    clear_log();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    idle(TO - 1);
    check("to_not_yet", load_error, 1'b0);
    idle(1);
    check("to_fired", load_error, 1'b1);
    check("to_halt", cpu_halt, 1'b1);
    check("to_nwrites", wq.size(), 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h2F); send_byte(8'h2F);
    idle(4);
    check("to_recover_err", load_error, 1'b0);
    check("to_recover_done", load_done, 1'b1);
    check("to_recover_halt", cpu_halt, 1'b0);

    // Maximum length frame fills all 16 words without wrapping.
    clear_log();
    csum = 8'd0;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(3 * i + 1));
      csum = csum + 8'(3 * i + 1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum);
`endif
    idle(4);
    check("max_nwrites", wq.size(), 16);
    check("max_w0", wq_at(0), 16'h0001);
    check("max_w15", wq_at(15), 16'h0F2E);
    check("max_done", load_done, 1'b1);
    check("max_err", load_error, 1'b0);

    // Reset after the 2nd data byte of a 4-byte frame, with a byte presented on the reset edge.
    clear_log();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    idle(1);
    check("mr_nwrites_at_rst", wq.size(), 2);
    check("mr_w1", wq_at(1), 16'h0102);
    check("mr_in_ready", in_ready, 1'b0);
    check("mr_mem_we", mem_we, 1'b0);
    check("mr_mem_addr", mem_addr, 4'd0);
    check("mr_mem_wdata", mem_wdata, 8'd0);
    check("mr_halt", cpu_halt, 1'b0);
    check("mr_restart", cpu_restart, 1'b0);
    check("mr_done", load_done, 1'b0);
    check("mr_err", load_error, 1'b0);
    idle(2);
    rst = 1'b0; in_valid = 1'b0;
    idle(4);
    check("mr_no_write_after", wq.size(), 2);
    check("mr_in_ready_after", in_ready, 1'b1);
    check("mr_halt_after", cpu_halt, 1'b0);
    check("mr_restarts", n_restart, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
